// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a multi-cycle 32-bit MIPS-subset datapath. It sequences
// FETCH / DECODE / EXEC / MEM / WB and drives the datapath muxes, ALU control,
// register-file and memory strobes. Memory accesses use a ready handshake
// from the shared instruction/data memory, guarded by a timeout counter.
//
// Ports
//   clk, rst               clock (rising edge), synchronous active-high reset
//   opcode, funct          instr[31:26] / instr[5:0] from the IR register
//   zero                   ALU zero flag (used by BEQ in EXEC)
//   mem_ready              memory completed the current access this cycle
//   PCWrite, PCSrc         PC load enable and next-PC select (00/01/10)
//   IorD                   memory address select (0 = PC, 1 = ALU result)
//   IRWrite                IR load enable
//   MemRead, MemWrite      memory requests
//   ALUSrc, ExtOp, ALUOp   ALU operand-B select, immediate extension, ALU op
//   RegDst, MemtoReg       register-file write address / data selects
//   RegWrite               register-file write enable
//   illegal, bus_err       sticky error flags (cleared only by rst)
//   state                  current FSM state for debug
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       ExtOp,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // Counter value on the last permitted wait cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [2:0]      r_state;
  logic [5:0]      r_op;
  logic [TO_W-1:0] r_cnt;
  logic            r_illegal;
  logic            r_bus_err;

  logic [2:0]      w_next;
  logic            w_wait;
  logic            w_timeout;
  logic            w_bad_op;
  logic            w_unused_funct;

  // funct is decoded by the ALU control, not by this FSM.
  assign w_unused_funct = ^funct;

  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      OP_R, OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW: is_supported = 1'b1;
      default:                                          is_supported = 1'b0;
    endcase
  endfunction

  assign w_wait    = (r_state == S_FETCH) || (r_state == S_MEM);
  // Timeout fires only on the last permitted wait with ready still low;
  // ready on that same cycle counts as success.
  assign w_timeout = w_wait && !mem_ready && (r_cnt == TO_LAST);
  assign w_bad_op  = (r_state == S_DECODE) && !is_supported(opcode);

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (is_supported(opcode)) begin
          w_next = S_EXEC;
        end else begin
          w_next = S_TRAP;
        end
      end
      S_EXEC: begin
        case (r_op)
          OP_R, OP_ADDI, OP_ORI: w_next = S_WB;
          OP_LW, OP_SW:          w_next = S_MEM;
          OP_BEQ, OP_J:          w_next = S_FETCH;
          default:               w_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (r_op == OP_LW) begin
            w_next = S_WB;
          end else begin
            w_next = S_FETCH;
          end
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end else begin
          w_next = S_MEM;
        end
      end
      S_WB:    w_next = S_FETCH;
      S_TRAP:  w_next = S_TRAP;
      // Unused encodings are treated as a fault and parked in TRAP.
      default: w_next = S_TRAP;
    endcase
  end

  // State, latched opcode, timeout counter and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_op      <= 6'h00;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op <= opcode;
      end else begin
        r_op <= r_op;
      end
      // Any state change clears the counter, so it starts at zero on entry
      // to FETCH or MEM; it only advances while waiting on memory.
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (w_wait && !mem_ready) begin
        r_cnt <= r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
      r_illegal <= r_illegal | w_bad_op;
      r_bus_err <= r_bus_err | w_timeout;
    end
  end

  // Control strobes from state and latched opcode; all low while rst is high.
  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = 2'b00;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    ExtOp    = 1'b0;
    ALUOp    = 2'b00;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          IorD    = 1'b0;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end else begin
            IRWrite = 1'b0;
            PCWrite = 1'b0;
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_R: begin
              ALUSrc = 1'b0;
              ALUOp  = 2'b10;
            end
            OP_ADDI, OP_LW, OP_SW: begin
              ALUSrc = 1'b1;
              ExtOp  = 1'b1;
              ALUOp  = 2'b00;
            end
            OP_ORI: begin
              ALUSrc = 1'b1;
              ExtOp  = 1'b0;
              ALUOp  = 2'b11;
            end
            OP_BEQ: begin
              // PCSrc stays on the branch target; zero only gates the load.
              ALUSrc  = 1'b0;
              ExtOp   = 1'b1;
              ALUOp   = 2'b01;
              PCSrc   = 2'b01;
              PCWrite = zero;
            end
            OP_J: begin
              PCSrc   = 2'b10;
              PCWrite = 1'b1;
            end
            default: ALUOp = 2'b00;
          endcase
        end
        S_MEM: begin
          IorD = 1'b1;
          if (r_op == OP_LW) begin
            MemRead = 1'b1;
          end else if (r_op == OP_SW) begin
            MemWrite = 1'b1;
          end else begin
            MemRead = 1'b0;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          case (r_op)
            OP_LW: begin
              MemtoReg = 1'b1;
              RegDst   = 1'b0;
            end
            OP_R:    RegDst = 1'b1;
            default: RegDst = 1'b0;
          endcase
        end
        default: PCWrite = 1'b0;
      endcase
    end else begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      PCWrite  = 1'b0;
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign bus_err = r_bus_err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl with MEM_TIMEOUT = 4. Each scenario
// builds a per-cycle stimulus plan; the expected output vector of every cycle
// is pushed to a scoreboard as the stimulus is driven and popped when the
// settled DUT outputs are compared (1 ns after the falling edge).
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;

  typedef logic [18:0] vec_t;
  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic       z;
    logic       r;
    vec_t       exp;
  } row_t;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IorD;
  logic       IRWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       ALUSrc;
  logic       ExtOp;
  logic [1:0] ALUOp;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       illegal;
  logic       bus_err;
  logic [2:0] state;

  int   n_checks;
  int   n_errors;
  row_t plan[$];
  vec_t sb[$];
  vec_t exp_v;
  vec_t obs_v;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUOp(ALUOp), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal(illegal),
    .bus_err(bus_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: state,PCWrite,PCSrc,IorD,IRWrite,MemRead,MemWrite,ALUSrc,ExtOp,ALUOp,RegDst,MemtoReg,RegWrite,illegal,bus_err
  function automatic vec_t ev(logic [2:0] st, logic pcw, logic [1:0] pcs, logic iord, logic irw,
                              logic mr, logic mw, logic asrc, logic ext, logic [1:0] aop,
                              logic rdst, logic m2r, logic rw, logic ill, logic be);
    return {st, pcw, pcs, iord, irw, mr, mw, asrc, ext, aop, rdst, m2r, rw, ill, be};
  endfunction

  function automatic vec_t obs_vec();
    return {state, PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, ALUSrc, ExtOp, ALUOp,
            RegDst, MemtoReg, RegWrite, illegal, bus_err};
  endfunction

  // Expected-vector shorthands for each state.
  function automatic vec_t e_fetch(logic rdy);
    return ev(3'd0, rdy, 2'b00, L0, rdy, L1, L0, L0, L0, 2'b00, L0, L0, L0, L0, L0);
  endfunction
  function automatic vec_t e_idle(logic [2:0] st, logic ill, logic be);
    return ev(st, L0, 2'b00, L0, L0, L0, L0, L0, L0, 2'b00, L0, L0, L0, ill, be);
  endfunction
  function automatic vec_t e_exec(logic asrc, logic ext, logic [1:0] aop, logic pcw, logic [1:0] pcs);
    return ev(3'd2, pcw, pcs, L0, L0, L0, L0, asrc, ext, aop, L0, L0, L0, L0, L0);
  endfunction
  function automatic vec_t e_mem(logic mr, logic mw);
    return ev(3'd3, L0, 2'b00, L1, L0, mr, mw, L0, L0, 2'b00, L0, L0, L0, L0, L0);
  endfunction
  function automatic vec_t e_wb(logic rdst, logic m2r);
    return ev(3'd4, L0, 2'b00, L0, L0, L0, L0, L0, L0, 2'b00, rdst, m2r, L1, L0, L0);
  endfunction

  task automatic add(input logic [5:0] op, input logic rdy, input logic z, input logic r, input vec_t e);
    row_t row;
    row.op = op; row.rdy = rdy; row.z = z; row.r = r; row.exp = e;
    plan.push_back(row);
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    sb.push_back(e_idle(3'd0, L0, L0));
    @(negedge clk); @(negedge clk);
    #1;
    exp_v = sb.pop_front();
    obs_v = obs_vec();
    n_checks++;
    if (obs_v !== exp_v) begin
      n_errors++;
      $display("FAIL reset: got %b expected %b", obs_v, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_alu();
    add(6'h08, L1, L0, L0, e_fetch(L1));
    add(6'h08, L1, L0, L0, e_idle(3'd1, L0, L0));
    add(6'h08, L1, L0, L0, e_exec(L1, L1, 2'b00, L0, 2'b00));
    add(6'h08, L1, L0, L0, e_wb(L0, L0));
    add(6'h00, L1, L0, L0, e_fetch(L1));
    add(6'h00, L1, L0, L0, e_idle(3'd1, L0, L0));
    add(6'h00, L1, L0, L0, e_exec(L0, L0, 2'b10, L0, 2'b00));
    add(6'h00, L1, L0, L0, e_wb(L1, L0));
    add(6'h0D, L1, L0, L0, e_fetch(L1));
    add(6'h0D, L1, L0, L0, e_idle(3'd1, L0, L0));
    add(6'h0D, L1, L0, L0, e_exec(L1, L0, 2'b11, L0, 2'b00));
    add(6'h0D, L1, L0, L0, e_wb(L0, L0));
    foreach (plan[i]) begin
      opcode = plan[i].op; mem_ready = plan[i].rdy; zero = plan[i].z; rst = plan[i].r;
      sb.push_back(plan[i].exp);
      #1;
      exp_v = sb.pop_front(); obs_v = obs_vec(); n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL alu row %0d: got %b expected %b", i, obs_v, exp_v);
      end
      @(negedge clk);
    end
    plan.delete();
  endtask

  task automatic test_mem();
    add(6'h23, L1, L0, L0, e_fetch(L1));
    add(6'h23, L1, L0, L0, e_idle(3'd1, L0, L0));
    add(6'h23, L1, L0, L0, e_exec(L1, L1, 2'b00, L0, 2'b00));
    for (int k = 0; k < 3; k++) add(6'h23, L0, L0, L0, e_mem(L1, L0));
    add(6'h23, L1, L0, L0, e_mem(L1, L0));
    add(6'h23, L1, L0, L0, e_wb(L0, L1));
    add(6'h2B, L1, L0, L0, e_fetch(L1));
    add(6'h2B, L1, L0, L0, e_idle(3'd1, L0, L0));
    add(6'h2B, L1, L0, L0, e_exec(L1, L1, 2'b00, L0, 2'b00));
    add(6'h2B, L1, L0, L0, e_mem(L0, L1));
    foreach (plan[i]) begin
      opcode = plan[i].op; mem_ready = plan[i].rdy; zero = plan[i].z; rst = plan[i].r;
      sb.push_back(plan[i].exp);
      #1;
      exp_v = sb.pop_front(); obs_v = obs_vec(); n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL mem row %0d: got %b expected %b", i, obs_v, exp_v);
      end
      @(negedge clk);
    end
    plan.delete();
  endtask

  task automatic test_branch();
    add(6'h04, L1, L1, L0, e_fetch(L1));
    add(6'h04, L1, L1, L0, e_idle(3'd1, L0, L0));
    add(6'h04, L1, L1, L0, e_exec(L0, L1, 2'b01, L1, 2'b01));
    add(6'h04, L1, L0, L0, e_fetch(L1));
    add(6'h04, L1, L0, L0, e_idle(3'd1, L0, L0));
    add(6'h04, L1, L0, L0, e_exec(L0, L1, 2'b01, L0, 2'b01));
    add(6'h02, L1, L0, L0, e_fetch(L1));
    add(6'h02, L1, L0, L0, e_idle(3'd1, L0, L0));
    add(6'h02, L1, L0, L0, e_exec(L0, L0, 2'b00, L1, 2'b10));
    foreach (plan[i]) begin
      opcode = plan[i].op; mem_ready = plan[i].rdy; zero = plan[i].z; rst = plan[i].r;
      sb.push_back(plan[i].exp);
      #1;
      exp_v = sb.pop_front(); obs_v = obs_vec(); n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL branch row %0d: got %b expected %b", i, obs_v, exp_v);
      end
      @(negedge clk);
    end
    plan.delete();
  endtask

  task automatic test_fetch_last_wait();
    for (int k = 0; k < 3; k++) add(6'h02, L0, L0, L0, e_fetch(L0));
    add(6'h02, L1, L0, L0, e_fetch(L1));
    add(6'h02, L1, L0, L0, e_idle(3'd1, L0, L0));
    add(6'h02, L1, L0, L0, e_exec(L0, L0, 2'b00, L1, 2'b10));
    foreach (plan[i]) begin
      opcode = plan[i].op; mem_ready = plan[i].rdy; zero = plan[i].z; rst = plan[i].r;
      sb.push_back(plan[i].exp);
      #1;
      exp_v = sb.pop_front(); obs_v = obs_vec(); n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL fetch_last_wait row %0d: got %b expected %b", i, obs_v, exp_v);
      end
      @(negedge clk);
    end
    plan.delete();
  endtask

  task automatic test_illegal();
    add(6'h3F, L1, L0, L0, e_fetch(L1));
    add(6'h3F, L1, L0, L0, e_idle(3'd1, L0, L0));
    for (int k = 0; k < 10; k++) add(6'h08, logic'(k % 2), L1, L0, e_idle(3'd7, L1, L0));
    add(6'h08, L1, L0, L1, e_idle(3'd7, L1, L0));
    add(6'h08, L1, L0, L1, e_idle(3'd0, L0, L0));
    foreach (plan[i]) begin
      opcode = plan[i].op; mem_ready = plan[i].rdy; zero = plan[i].z; rst = plan[i].r;
      sb.push_back(plan[i].exp);
      #1;
      exp_v = sb.pop_front(); obs_v = obs_vec(); n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL illegal row %0d: got %b expected %b", i, obs_v, exp_v);
      end
      @(negedge clk);
    end
    plan.delete();
  endtask

  task automatic test_bus_err();
    for (int k = 0; k < 4; k++) add(6'h08, L0, L0, L0, e_fetch(L0));
    for (int k = 0; k < 3; k++) add(6'h08, L1, L0, L0, e_idle(3'd7, L0, L1));
    add(6'h08, L1, L0, L1, e_idle(3'd7, L0, L1));
    add(6'h08, L1, L0, L1, e_idle(3'd0, L0, L0));
    foreach (plan[i]) begin
      opcode = plan[i].op; mem_ready = plan[i].rdy; zero = plan[i].z; rst = plan[i].r;
      sb.push_back(plan[i].exp);
      #1;
      exp_v = sb.pop_front(); obs_v = obs_vec(); n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL bus_err row %0d: got %b expected %b", i, obs_v, exp_v);
      end
      @(negedge clk);
    end
    plan.delete();
  endtask

  task automatic test_rst_mid();
    add(6'h2B, L1, L0, L0, e_fetch(L1));
    add(6'h2B, L1, L0, L0, e_idle(3'd1, L0, L0));
    add(6'h2B, L1, L0, L0, e_exec(L1, L1, 2'b00, L0, 2'b00));
    add(6'h2B, L0, L0, L0, e_mem(L0, L1));
    add(6'h2B, L0, L0, L0, e_mem(L0, L1));
    add(6'h2B, L0, L0, L1, e_idle(3'd3, L0, L0));
    add(6'h2B, L0, L0, L1, e_idle(3'd0, L0, L0));
    add(6'h2B, L1, L0, L0, e_fetch(L1));
    add(6'h2B, L1, L0, L0, e_idle(3'd1, L0, L0));
    foreach (plan[i]) begin
      opcode = plan[i].op; mem_ready = plan[i].rdy; zero = plan[i].z; rst = plan[i].r;
      sb.push_back(plan[i].exp);
      #1;
      exp_v = sb.pop_front(); obs_v = obs_vec(); n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL rst_mid row %0d: got %b expected %b", i, obs_v, exp_v);
      end
      @(negedge clk);
    end
    plan.delete();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_fetch_last_wait();
    test_illegal();
    test_bus_err();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
